// File: rtl/fir_coeff_bank_if.sv
// CSR-side and FIR-side signals of the coefficient bank controller.
// Tap addresses carry one spare bit so that out-of-range indices reach the drop check.
interface fir_coeff_bank_if #(
  parameter int NUM_TAPS = 32,
  parameter int COEFF_W  = 16,
  parameter int ADDR_W   = $clog2(NUM_TAPS) + 1
);
  logic                        cfg_wr_en;
  logic [ADDR_W-1:0]           cfg_wr_addr;
  logic [COEFF_W-1:0]          cfg_wr_data;
  logic                        cfg_commit;
  logic                        cfg_busy;
  logic                        cfg_wr_drop;
  logic [7:0]                  cfg_swap_count;
  logic                        signal_valid;
  logic                        fir_out_valid;
  logic                        out_valid_gated;
  logic [NUM_TAPS*COEFF_W-1:0] coeff_active;

  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit, signal_valid, fir_out_valid,
    input  cfg_busy, cfg_wr_drop, cfg_swap_count, out_valid_gated, coeff_active
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit, signal_valid, fir_out_valid,
    output cfg_busy, cfg_wr_drop, cfg_swap_count, out_valid_gated, coeff_active
  );
endinterface

// File: rtl/fir_coeff_bank_ctrl.sv
// Double-buffered FIR coefficient bank with atomic swap on a sample strobe and
// output-valid masking until the adder pipeline holds only new-coefficient results.
//
// state   | meaning
// IDLE    | shadow writable, no swap requested
// PENDING | commit seen, waiting for signal_valid to swap; writes dropped
// FLUSH   | swapped, masking fir_out_valid until the flush count expires
module fir_coeff_bank_ctrl #(
  parameter int NUM_TAPS      = 32,
  parameter int COEFF_W       = 16,
  parameter int FLUSH_SAMPLES = 6,
  parameter int ADDR_W        = $clog2(NUM_TAPS) + 1
) (
  input logic               clk,
  input logic               rst_n,
  fir_coeff_bank_if.slave   bus
);

  localparam int TAP_W = $clog2(NUM_TAPS);
  localparam int CNT_W = $clog2(FLUSH_SAMPLES + 1);
  localparam logic [ADDR_W-1:0] NUM_TAPS_A = ADDR_W'(NUM_TAPS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [NUM_TAPS-1:0][COEFF_W-1:0]  shadow_q, shadow_d;
  logic [NUM_TAPS-1:0][COEFF_W-1:0]  active_q, active_d;
  logic [CNT_W-1:0]                  flush_cnt_q, flush_cnt_d;
  logic [7:0]                        swap_count_q, swap_count_d;
  logic                              busy_q, busy_d;
  logic                              wr_drop_q, wr_drop_d;
  logic                              addr_ok;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    flush_cnt_d  = flush_cnt_q;
    swap_count_d = swap_count_q;
    wr_drop_d    = 1'b0;
    addr_ok      = (bus.cfg_wr_addr < NUM_TAPS_A);

    if (bus.cfg_wr_en) begin
      if (addr_ok && (state_q != PENDING)) begin
        shadow_d[bus.cfg_wr_addr[TAP_W-1:0]] = bus.cfg_wr_data;
      end else begin
        wr_drop_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.cfg_commit) state_d = PENDING;
      end
      PENDING: begin
        // Swap on the strobe edge: this sample still used the old bank.
        if (bus.signal_valid) begin
          active_d     = shadow_q;
          swap_count_d = swap_count_q + 8'd1;
          flush_cnt_d  = CNT_W'(FLUSH_SAMPLES);
          state_d      = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.cfg_commit) begin
          state_d = PENDING;
        end else if (bus.fir_out_valid) begin
          if (flush_cnt_q <= CNT_W'(1)) begin
            flush_cnt_d = '0;
            state_d     = IDLE;
          end else begin
            flush_cnt_d = flush_cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      active_q     <= '0;
      flush_cnt_q  <= '0;
      swap_count_q <= '0;
      busy_q       <= 1'b0;
      wr_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      flush_cnt_q  <= flush_cnt_d;
      swap_count_q <= swap_count_d;
      busy_q       <= busy_d;
      wr_drop_q    <= wr_drop_d;
    end
  end

  assign bus.cfg_busy        = busy_q;
  assign bus.cfg_wr_drop     = wr_drop_q;
  assign bus.cfg_swap_count  = swap_count_q;
  assign bus.coeff_active    = active_q;
  assign bus.out_valid_gated = bus.fir_out_valid & (state_q != FLUSH);

endmodule
